// File: rtl/tri_scan.sv
// -----------------------------------------------------------------------------
// tri_scan -- rasterizer front end for the point-in-triangle tester (tstTR).
//
// Accepts one triangle, computes its bounding box, then walks every point of
// the box in row-major order.  Each candidate point is presented, together
// with the latched vertices, to an external tstTR instance.  Points that the
// tester reports as inside are streamed out with backpressure and counted.
//
// Handshakes (both ports): a transfer happens on a rising edge where valid
// and ready are both high.  A valid output holds its payload stable until
// the transfer.  tri_ready never depends on tri_valid, and out_valid never
// depends on out_ready.
//
// Parameters:
//   W      coordinate width (unsigned)
//   SCR_W  screen width,  only used when TRI_SCAN_CLIP_EN is defined
//   SCR_H  screen height, only used when TRI_SCAN_CLIP_EN is defined
//
// Optional feature macro: TRI_SCAN_CLIP_EN
//   Defined   : the box is clamped to the screen; a box entirely off-screen
//               skips straight from SETUP to DONE with no candidates.
//   Undefined : the full box is scanned.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   tri_valid/ready     triangle input handshake
//   tri_vtx             {CY,CX,BY,BX,AY,AX}, AX in the low bits
//   test_vtx            latched vertices to the tester (same packing)
//   test_cx, test_cy    candidate point to the tester (registered)
//   test_ins            tester verdict for the current candidate (same cycle)
//   out_valid/ready     inside-pixel output handshake
//   out_x, out_y        inside-pixel coordinates
//   busy                high in SETUP/SCAN/DONE
//   done                one-cycle pulse at the end of a triangle
//   pix_count           inside pixels emitted for the current/last triangle
//   dbgState            current FSM state (IDLE=0, SETUP=1, SCAN=2, DONE=3)
// -----------------------------------------------------------------------------
module tri_scan #(
  parameter int W     = 12,
  parameter int SCR_W = 640,
  parameter int SCR_H = 480
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tri_valid,
  output logic           tri_ready,
  input  logic [6*W-1:0] tri_vtx,
  output logic [6*W-1:0] test_vtx,
  output logic [W-1:0]   test_cx,
  output logic [W-1:0]   test_cy,
  input  logic           test_ins,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_x,
  output logic [W-1:0]   out_y,
  output logic           busy,
  output logic           done,
  output logic [2*W:0]   pix_count,
  output logic [1:0]     dbgState
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, nextState;

  logic [6*W-1:0] vtxReg;
  logic [W-1:0]   minX, maxX, minY, maxY;
  logic [W-1:0]   curX, curY;
  logic [2*W:0]   pixCount;

  // ---------------------------------------------------------------------------
  // Bounding box of the latched vertices (evaluated during SETUP)
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] min3(input logic [W-1:0] a, b, c);
    logic [W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [W-1:0] max3(input logic [W-1:0] a, b, c);
    logic [W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  logic [W-1:0] ax, ay, bx, by, cx, cy;
  logic [W-1:0] boxMinX, boxMaxX, boxMinY, boxMaxY;
  logic [W-1:0] clipMaxX, clipMaxY;
  logic         offScreen;

  assign ax = vtxReg[0*W +: W];
  assign ay = vtxReg[1*W +: W];
  assign bx = vtxReg[2*W +: W];
  assign by = vtxReg[3*W +: W];
  assign cx = vtxReg[4*W +: W];
  assign cy = vtxReg[5*W +: W];

  assign boxMinX = min3(ax, bx, cx);
  assign boxMaxX = max3(ax, bx, cx);
  assign boxMinY = min3(ay, by, cy);
  assign boxMaxY = max3(ay, by, cy);

`ifdef TRI_SCAN_CLIP_EN
  localparam logic [W-1:0] SCR_X_MAX = W'(SCR_W - 1);
  localparam logic [W-1:0] SCR_Y_MAX = W'(SCR_H - 1);

  assign clipMaxX  = (boxMaxX > SCR_X_MAX) ? SCR_X_MAX : boxMaxX;
  assign clipMaxY  = (boxMaxY > SCR_Y_MAX) ? SCR_Y_MAX : boxMaxY;
  assign offScreen = (boxMinX > SCR_X_MAX) || (boxMinY > SCR_Y_MAX);
`else
  // Screen size is irrelevant without clipping.
  logic unusedScr;
  assign unusedScr = ^{SCR_W[0], SCR_H[0]};

  assign clipMaxX  = boxMaxX;
  assign clipMaxY  = boxMaxY;
  assign offScreen = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Scan control
  // ---------------------------------------------------------------------------
  logic inScan;
  logic advance;
  logic lastPt;

  assign inScan  = (state == SCAN);
  // Move on when the candidate is outside, or when the inside pixel is taken.
  assign advance = inScan && (!test_ins || out_ready);
  assign lastPt  = (curX == maxX) && (curY == maxY);

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:  if (tri_valid)         nextState = SETUP;
      SETUP: nextState = offScreen ? DONE : SCAN;
      SCAN:  if (advance && lastPt) nextState = DONE;
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      vtxReg   <= '0;
      minX     <= '0;
      maxX     <= '0;
      minY     <= '0;
      maxY     <= '0;
      curX     <= '0;
      curY     <= '0;
      pixCount <= '0;
    end else begin
      state <= nextState;
      unique case (state)
        IDLE: begin
          if (tri_valid) begin
            vtxReg   <= tri_vtx;
            pixCount <= '0;
          end
        end
        SETUP: begin
          minX <= boxMinX;
          maxX <= clipMaxX;
          minY <= boxMinY;
          maxY <= clipMaxY;
          curX <= boxMinX;
          curY <= boxMinY;
        end
        SCAN: begin
          // Count cannot wrap: at most 2^(2W) points fit in 2W+1 bits.
          if (test_ins && out_ready) pixCount <= pixCount + (2*W+1)'(1);
          if (advance) begin
            // On the very last point curY may wrap, but the scan ends there.
            if (curX == maxX) begin
              curX <= minX;
              curY <= curY + W'(1);
            end else begin
              curX <= curX + W'(1);
            end
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign tri_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign test_vtx  = vtxReg;
  assign test_cx   = curX;
  assign test_cy   = curY;
  assign out_valid = inScan && test_ins;
  assign out_x     = curX;
  assign out_y     = curY;
  assign pix_count = pixCount;
  assign dbgState  = state;

endmodule

// File: tb/tb_tri_scan.sv
// -----------------------------------------------------------------------------
// tb_tri_scan -- self-checking bench for tri_scan (default build).
// The tester (tstTR) is modelled by an inclusive edge-function test driven
// combinationally from the DUT's test_vtx/test_cx/test_cy.
// -----------------------------------------------------------------------------
module tb_tri_scan;
  localparam int W = 12;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           tri_valid;
  logic           tri_ready;
  logic [6*W-1:0] tri_vtx;
  logic [6*W-1:0] test_vtx;
  logic [W-1:0]   test_cx;
  logic [W-1:0]   test_cy;
  logic           test_ins;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_x;
  logic [W-1:0]   out_y;
  logic           busy;
  logic           done;
  logic [2*W:0]   pix_count;
  logic [1:0]     dbgState;

  tri_scan #(.W(W), .SCR_W(640), .SCR_H(480)) dut (
    .clk       (clk),
    .rst       (rst),
    .tri_valid (tri_valid),
    .tri_ready (tri_ready),
    .tri_vtx   (tri_vtx),
    .test_vtx  (test_vtx),
    .test_cx   (test_cx),
    .test_cy   (test_cy),
    .test_ins  (test_ins),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .busy      (busy),
    .done      (done),
    .pix_count (pix_count),
    .dbgState  (dbgState)
  );

  // ---------------------------------------------------------------------------
  // Tester model (point-in-triangle, edges inclusive, either winding)
  // ---------------------------------------------------------------------------
  function automatic logic inTri(input logic [6*W-1:0] v,
                                 input logic [W-1:0] px, input logic [W-1:0] py);
    longint ax, ay, bx, by, cx, cy, x, y, e0, e1, e2;
    ax = longint'(v[0*W +: W]); ay = longint'(v[1*W +: W]);
    bx = longint'(v[2*W +: W]); by = longint'(v[3*W +: W]);
    cx = longint'(v[4*W +: W]); cy = longint'(v[5*W +: W]);
    x  = longint'(px);          y  = longint'(py);
    e0 = (bx - ax) * (y - ay) - (by - ay) * (x - ax);
    e1 = (cx - bx) * (y - by) - (cy - by) * (x - bx);
    e2 = (ax - cx) * (y - cy) - (ay - cy) * (x - cx);
    return ((e0 >= 0) && (e1 >= 0) && (e2 >= 0)) ||
           ((e0 <= 0) && (e1 <= 0) && (e2 <= 0));
  endfunction

  assign test_ins = inTri(test_vtx, test_cx, test_cy);

  function automatic logic [6*W-1:0] mkTri(input int ax, input int ay, input int bx,
                                           input int by, input int cx, input int cy);
    return {W'(cy), W'(cx), W'(by), W'(bx), W'(ay), W'(ax)};
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [2*W-1:0] exp_q[$];
  logic [2*W:0]   lastCount;
  int nCmp  = 0;
  int nFail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one triangle, entered and left at a negedge with the DUT idle.
  //   bp      : stall each inside pixel for two cycles
  //   hold    : keep tri_valid high through the whole scan
  //   abortAt : if nonzero, assert rst in that SCAN cycle
  // ---------------------------------------------------------------------------
  task automatic runTri(input logic [6*W-1:0] v, input int bp, input int hold,
                        input int expCands, input int abortAt);
    int c[6];
    logic [W-1:0] mnX, mxX, mnY, mxY, expX, expY;
    logic [2*W:0] cnt;
    logic [2*W-1:0] want;
    int cycles, cand, stall;

    for (int i = 0; i < 6; i++) c[i] = int'(v[i*W +: W]);
    mnX = W'((c[0] < c[2]) ? ((c[0] < c[4]) ? c[0] : c[4]) : ((c[2] < c[4]) ? c[2] : c[4]));
    mxX = W'((c[0] > c[2]) ? ((c[0] > c[4]) ? c[0] : c[4]) : ((c[2] > c[4]) ? c[2] : c[4]));
    mnY = W'((c[1] < c[3]) ? ((c[1] < c[5]) ? c[1] : c[5]) : ((c[3] < c[5]) ? c[3] : c[5]));
    mxY = W'((c[1] > c[3]) ? ((c[1] > c[5]) ? c[1] : c[5]) : ((c[3] > c[5]) ? c[3] : c[5]));

    exp_q.delete();
    cnt = '0;
    for (int y = int'(mnY); y <= int'(mxY); y++)
      for (int x = int'(mnX); x <= int'(mxX); x++)
        if (inTri(v, W'(x), W'(y))) begin
          exp_q.push_back({W'(y), W'(x)});
          cnt++;
        end

    check("idle_ready", tri_ready, 1);
    check("idle_busy",  busy, 0);
    check("idle_done",  done, 0);
    check("idle_pix",   pix_count, lastCount);

    tri_vtx   = v;
    tri_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    if (hold == 0) tri_valid = 1'b0;
    check("setup_ready", tri_ready, 0);
    check("setup_busy",  busy, 1);
    check("setup_pix",   pix_count, 0);
    check("setup_vtx",   test_vtx, v);
    @(negedge clk);

    expX = mnX; expY = mnY; cycles = 0; cand = 0; stall = 0;
    while (done !== 1'b1 && cycles < expCands * 4 + 20) begin
      check("cand_xy",    {test_cy, test_cx}, {expY, expX});
      check("out_xy",     {out_y, out_x},     {expY, expX});
      check("scan_ready", tri_ready, 0);
      check("scan_valid", out_valid, inTri(v, expX, expY));

      if (abortAt != 0 && cycles == abortAt - 1) begin
        rst       = 1'b1;
        tri_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_ready", tri_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_busy",  busy, 0);
        check("rst_pix",   pix_count, 0);
        rst = 1'b0;
        exp_q.delete();
        lastCount = '0;
        return;
      end

      if (bp != 0 && out_valid && stall < 2) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
      end

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          nCmp++; nFail++;
          $display("FAIL pixel_extra: actual=%0h required=none", {out_y, out_x});
        end else begin
          want = exp_q.pop_front();
          check("pixel", {out_y, out_x}, want);
        end
        stall = 0;
      end

      if (!out_valid || out_ready) begin
        cand++;
        if (expX == mxX) begin
          expX = mnX;
          expY = expY + W'(1);
        end else begin
          expX = expX + W'(1);
        end
      end

      @(negedge clk);
      cycles++;
    end

    check("done_seen",  done, 1);
    check("cand_count", cand, expCands);
    check("pix_count",  pix_count, cnt);
    check("done_ready", tri_ready, 0);
    check("done_valid", out_valid, 0);
    check("q_empty",    exp_q.size(), 0);
    lastCount = cnt;
    out_ready = 1'b1;
    @(negedge clk);
    check("done_pulse", done, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [6*W-1:0] vtx;
    int bp;
    int hold;
    int expCands;
  } vec_t;

  vec_t vecs[8];

  initial begin
    rst       = 1'b1;
    tri_valid = 1'b0;
    tri_vtx   = '0;
    out_ready = 1'b0;
    lastCount = '0;

    vecs[0] = '{mkTri(10, 10, 30, 10, 20, 30), 0, 0, 441};  // basic
    vecs[1] = '{mkTri(10, 10, 30, 10, 20, 30), 1, 0, 441};  // backpressure
    vecs[2] = '{mkTri(5, 5, 5, 5, 5, 5),       0, 0, 1};    // single point
    vecs[3] = '{mkTri(0, 0, 7, 0, 0, 3),       0, 1, 32};   // tri_valid held
    vecs[4] = '{mkTri(3, 9, 1, 2, 6, 4),       0, 0, 48};   // accepted right after
    vecs[5] = '{mkTri(2, 2, 4, 4, 6, 6),       1, 0, 25};   // collinear
    vecs[6] = '{mkTri(4090, 4095, 4095, 4093, 4093, 4090), 0, 0, 36};  // top corner
    vecs[7] = '{mkTri(0, 0, 0, 0, 4095, 0),    0, 0, 4096}; // full-width row

    repeat (3) @(negedge clk);
    check("reset_ready", tri_ready, 1);
    check("reset_valid", out_valid, 0);
    check("reset_done",  done, 0);
    check("reset_busy",  busy, 0);
    check("reset_pix",   pix_count, 0);
    check("reset_cand",  {test_cy, test_cx}, 0);
    check("reset_out",   {out_y, out_x}, 0);
    check("reset_vtx",   test_vtx, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      runTri(vecs[i].vtx, vecs[i].bp, vecs[i].hold, vecs[i].expCands, 0);

    // Small random triangles with random backpressure.
    for (int i = 0; i < 4; i++) begin
      int p[6];
      int wd, ht;
      for (int k = 0; k < 6; k++) p[k] = int'($urandom_range(0, 12));
      wd = ((p[0] > p[2] ? (p[0] > p[4] ? p[0] : p[4]) : (p[2] > p[4] ? p[2] : p[4]))
          - (p[0] < p[2] ? (p[0] < p[4] ? p[0] : p[4]) : (p[2] < p[4] ? p[2] : p[4]))) + 1;
      ht = ((p[1] > p[3] ? (p[1] > p[5] ? p[1] : p[5]) : (p[3] > p[5] ? p[3] : p[5]))
          - (p[1] < p[3] ? (p[1] < p[5] ? p[1] : p[5]) : (p[3] < p[5] ? p[3] : p[5]))) + 1;
      runTri(mkTri(p[0], p[1], p[2], p[3], p[4], p[5]), int'($urandom_range(0, 1)), 0,
             wd * ht, 0);
    end

    // Reset in the 100th SCAN cycle, then a clean rescan.
    runTri(mkTri(10, 10, 30, 10, 20, 30), 0, 0, 441, 100);
    runTri(mkTri(10, 10, 30, 10, 20, 30), 0, 0, 441, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/tri_scan.md
Name: tri_scan

Overview:
- Rasterizer front end for the point-in-triangle tester (tstTR).
- Accepts one triangle over a valid/ready handshake and computes its bounding box.
- Walks every candidate point of the box in row-major order and drives each point, with the triangle vertices, into an external tstTR instance.
- Streams out the points that tester reports inside, with backpressure, and counts them.

Parameters:
- W, 12, coordinate width in bits (unsigned, 0..2^W-1).
- SCR_W, 640, screen width in pixels; used only with TRI_SCAN_CLIP_EN.
- SCR_H, 480, screen height in pixels; used only with TRI_SCAN_CLIP_EN.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- tri_valid  input  1  triangle present on tri_vtx.
- tri_ready  output  1  block can accept a triangle.
- tri_vtx  input  6*W  {CY,CX,BY,BX,AY,AX}; AX in bits [W-1:0].
- test_vtx  output  6*W  latched vertices to tester, same packing; order to tstTR is A,B,3=C.
- test_cx  output  W  candidate point X to tester.
- test_cy  output  W  candidate point Y to tester.
- test_ins  input  1  tester result for the current candidate; combinational, same cycle.
- out_valid  output  1  inside pixel presented.
- out_ready  input  1  downstream accepts the pixel.
- out_x  output  W  inside pixel X.
- out_y  output  W  inside pixel Y.
- busy  output  1  high in SETUP/SCAN/DONE.
- done  output  1  one-cycle pulse at end of triangle.
- pix_count  output  2*W+1  number of inside pixels emitted for the current/last triangle.

Behaviour:
- Reset: state IDLE; tri_ready=1; out_valid=0; done=0; busy=0; pix_count=0; test_vtx, test_cx, test_cy, out_x, out_y all 0.
- Reset asserted mid-scan aborts immediately. No pixel handshake completes in the reset cycle.
- FSM states: IDLE, SETUP, SCAN, DONE.
- IDLE:
  - tri_ready=1.
  - On tri_valid&tri_ready: latch tri_vtx into the vertex regs, clear pix_count, go to SETUP.
- SETUP (1 cycle):
  - Register min_x/max_x/min_y/max_y as unsigned min/max of the three vertices.
  - Set cur=(min_x,min_y).
  - Go to SCAN.
  - Accept-to-first-candidate latency is 2 cycles.
- SCAN:
  - test_cx/test_cy = cur (registered).
  - out_valid = test_ins (combinational); out_x/out_y = cur.
  - Advance when (!test_ins) or (out_valid&&out_ready). Otherwise hold cur, out_x, out_y stable.
  - Advance order: cur_x+1; at cur_x==max_x, wrap cur_x to min_x and increment cur_y.
  - pix_count increments on each out_valid&&out_ready.
  - Advancing from (max_x,max_y) goes to DONE. The last pixel's handshake and the transition occur in the same cycle.
  - With out_ready held high, throughput is 1 candidate per cycle.
  - A box of w×h takes exactly w*h SCAN cycles.
- DONE (1 cycle): done=1, tri_ready=0, out_valid=0; then IDLE.
- pix_count holds its value until the next accept.
- Degenerate triangle (all vertices equal or collinear): the box is still scanned. Emission is whatever tester reports; there is no special case.
- Counters never wrap: the maximum box is 2^W × 2^W, and pix_count is 2*W+1 bits.
- tri_ready=0 in SETUP/SCAN/DONE. A new triangle is accepted at the earliest one cycle after the done pulse.

Optional Feature:
- Macro: TRI_SCAN_CLIP_EN.
- When defined, SETUP clamps the box: max_x=min(max_x,SCR_W-1), max_y=min(max_y,SCR_H-1).
- When defined, if min_x>SCR_W-1 or min_y>SCR_H-1, SETUP goes directly to DONE with pix_count=0. No candidates are driven in that case.
- When undefined, the full unclipped box is scanned and SCR_W/SCR_H are ignored.

Test Plan:
- Basic scan: tri (10,10),(30,10),(20,30), out_ready=1, tstTR connected -> first candidate (10,10) 2 cycles after accept; exactly 441 SCAN cycles; done pulse; pix_count equals golden-model count of inside points. Golden model is tstTR evaluated over the box.
- Backpressure: same triangle, out_ready=0 whenever out_valid -> cur, out_x, out_y stable while stalled; candidate (15,15) emitted exactly once on release; final pix_count unchanged vs. basic scan.
- Degenerate: all vertices (5,5) -> exactly one candidate (5,5), then done; pix_count 0 or 1 matching tester output.
- Handshake: tri_valid held high through a scan -> tri_ready low during SETUP/SCAN/DONE; second triangle accepted only in the IDLE cycle after done.
- Reset mid-scan: rst at the 100th SCAN cycle -> next cycle IDLE, tri_ready=1, out_valid=0, pix_count=0; a new triangle scans correctly afterwards.
- Clip (TRI_SCAN_CLIP_EN, SCR_W=16, SCR_H=480), basic triangle -> x range 10..15, 126 candidates. With vertex box min_x=20 -> done 2 cycles after accept, pix_count=0.
